color_bbox_detect: RTL and testbench

- Downstream consumer of the camera output buffer FIFO, running on the FIFO read clock.
- Pops RGB565 pixels, tracks raster x/y and classifies each pixel against programmable per-channel thresholds.
- Accumulates per frame the match count and the bounding box of matching pixels, then publishes a registered result with a one-cycle strobe to the overlay/control logic.

---
 rtl/color_bbox_detect.sv | 226 ++++++++++++++++++++++
 tb/tb_color_bbox_detect.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/color_bbox_detect.sv
// Colour-threshold classifier and per-frame bounding-box accumulator fed from the camera output FIFO.
// Define COLOR_MASK_OUT_EN to expose the per-pixel classification stream (o_mask_*).
module color_bbox_detect #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int XW       = 10,
   parameter int YW       = 9,
   parameter int CW       = 19
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_sof,
   output logic          o_obuf_rd,
   input  logic [15:0]   i_obuf_data,
   input  logic          i_obuf_empty,
   input  logic [4:0]    i_r_min,
   input  logic [4:0]    i_r_max,
   input  logic [5:0]    i_g_min,
   input  logic [5:0]    i_g_max,
   input  logic [4:0]    i_b_min,
   input  logic [4:0]    i_b_max,
   output logic          o_done,
   output logic          o_found,
   output logic [CW-1:0] o_count,
   output logic [XW-1:0] o_xmin,
   output logic [XW-1:0] o_xmax,
   output logic [YW-1:0] o_ymin,
   output logic [YW-1:0] o_ymax,
   output logic          o_frame_err
`ifdef COLOR_MASK_OUT_EN
   ,
   output logic          o_mask_valid,
   output logic          o_mask,
   output logic [XW-1:0] o_mask_x,
   output logic [YW-1:0] o_mask_y
`endif
);

   localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

   typedef enum logic {WAIT_SOF, ACTIVE} state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   x_q, x_d, s1_x_q, s1_x_d, s2_x_q, s2_x_d;
   logic [YW-1:0]   y_q, y_d, s1_y_q, s1_y_d, s2_y_q, s2_y_d;
   logic            s1_v_q, s1_v_d, s1_last_q, s1_last_d;
   logic            s2_v_q, s2_v_d, s2_last_q, s2_last_d, s2_match_q, s2_match_d;
   logic            s3_last_q, s3_last_d;
   logic [CW-1:0]   acc_cnt_q, acc_cnt_d, cnt_b;
   logic [XW-1:0]   acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d, xmin_b, xmax_b;
   logic [YW-1:0]   acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d, ymin_b, ymax_b;
   logic            done_q, done_d, found_q, found_d, frame_err_q, frame_err_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XW-1:0]   xmin_q, xmin_d, xmax_q, xmax_d;
   logic [YW-1:0]   ymin_q, ymin_d, ymax_q, ymax_d;
   logic            rd, restart, at_last, in_range, fresh;
   logic [4:0]      pix_r, pix_b;
   logic [5:0]      pix_g;

   assign rd        = (state_q == ACTIVE) && !i_obuf_empty;
   assign o_obuf_rd = rd;

   always_comb begin
      // NOTE: every _d takes its hold value first, so no path through this block can infer a latch.
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      frame_err_d = frame_err_q;
      found_d     = found_q;
      count_d     = count_q;
      xmin_d      = xmin_q;
      xmax_d      = xmax_q;
      ymin_d      = ymin_q;
      ymax_d      = ymax_q;
      done_d      = 1'b0;

      // A start-of-frame while still active aborts the partial frame and everything in flight.
      restart = i_sof && (state_q == ACTIVE);
      at_last = (x_q == X_LAST) && (y_q == Y_LAST);

      if (i_sof) begin
         state_d = ACTIVE;
         x_d     = '0;
         y_d     = '0;
         if (restart) frame_err_d = 1'b1;
      end else if (rd) begin
         if (x_q == X_LAST) begin
            x_d = '0;
            if (y_q == Y_LAST) begin
               y_d     = '0;
               state_d = WAIT_SOF;
            end else begin
               y_d = y_q + 1'b1;
            end
         end else begin
            x_d = x_q + 1'b1;
         end
      end

      s1_v_d    = rd && !restart;
      s1_last_d = rd && !restart && at_last;
      s1_x_d    = x_q;
      s1_y_d    = y_q;

      pix_r      = i_obuf_data[15:11];
      pix_g      = i_obuf_data[10:5];
      pix_b      = i_obuf_data[4:0];
      in_range   = (pix_r >= i_r_min) && (pix_r <= i_r_max) &&
                   (pix_g >= i_g_min) && (pix_g <= i_g_max) &&
                   (pix_b >= i_b_min) && (pix_b <= i_b_max);
      s2_v_d     = s1_v_q && !restart;
      s2_last_d  = s1_last_q && s1_v_q && !restart;
      s2_match_d = s1_v_q && in_range;
      s2_x_d     = s1_x_q;
      s2_y_d     = s1_y_q;
      s3_last_d  = s2_last_q && s2_v_q && !restart;

      // Accumulators re-initialise as the finished frame is published, so the next frame's first pixel can land in the same cycle.
      fresh  = s3_last_q || restart;
      cnt_b  = fresh ? '0 : acc_cnt_q;
      xmin_b = fresh ? X_LAST : acc_xmin_q;
      xmax_b = fresh ? '0 : acc_xmax_q;
      ymin_b = fresh ? Y_LAST : acc_ymin_q;
      ymax_b = fresh ? '0 : acc_ymax_q;

      acc_cnt_d  = cnt_b;
      acc_xmin_d = xmin_b;
      acc_xmax_d = xmax_b;
      acc_ymin_d = ymin_b;
      acc_ymax_d = ymax_b;
      if (s2_v_q && s2_match_q && !restart) begin
         if (cnt_b != '1) acc_cnt_d = cnt_b + 1'b1;
         acc_xmin_d = (s2_x_q < xmin_b) ? s2_x_q : xmin_b;
         acc_xmax_d = (s2_x_q > xmax_b) ? s2_x_q : xmax_b;
         acc_ymin_d = (s2_y_q < ymin_b) ? s2_y_q : ymin_b;
         acc_ymax_d = (s2_y_q > ymax_b) ? s2_y_q : ymax_b;
      end

      if (s3_last_q) begin
         done_d  = 1'b1;
         found_d = (acc_cnt_q != '0);
         count_d = acc_cnt_q;
         xmin_d  = found_d ? acc_xmin_q : '0;
         xmax_d  = found_d ? acc_xmax_q : '0;
         ymin_d  = found_d ? acc_ymin_q : '0;
         ymax_d  = found_d ? acc_ymax_q : '0;
      end
   end

   always_ff @(posedge i_clk) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
      if (i_rst) begin
         state_q     <= WAIT_SOF;
         x_q         <= '0;
         y_q         <= '0;
         s1_v_q      <= 1'b0;
         s1_last_q   <= 1'b0;
         s1_x_q      <= '0;
         s1_y_q      <= '0;
         s2_v_q      <= 1'b0;
         s2_last_q   <= 1'b0;
         s2_match_q  <= 1'b0;
         s2_x_q      <= '0;
         s2_y_q      <= '0;
         s3_last_q   <= 1'b0;
         acc_cnt_q   <= '0;
         acc_xmin_q  <= X_LAST;
         acc_xmax_q  <= '0;
         acc_ymin_q  <= Y_LAST;
         acc_ymax_q  <= '0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         count_q     <= '0;
         xmin_q      <= '0;
         xmax_q      <= '0;
         ymin_q      <= '0;
         ymax_q      <= '0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         s1_v_q      <= s1_v_d;
         s1_last_q   <= s1_last_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s2_v_q      <= s2_v_d;
         s2_last_q   <= s2_last_d;
         s2_match_q  <= s2_match_d;
         s2_x_q      <= s2_x_d;
         s2_y_q      <= s2_y_d;
         s3_last_q   <= s3_last_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_xmin_q  <= acc_xmin_d;
         acc_xmax_q  <= acc_xmax_d;
         acc_ymin_q  <= acc_ymin_d;
         acc_ymax_q  <= acc_ymax_d;
         done_q      <= done_d;
         found_q     <= found_d;
         count_q     <= count_d;
         xmin_q      <= xmin_d;
         xmax_q      <= xmax_d;
         ymin_q      <= ymin_d;
         ymax_q      <= ymax_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign o_done      = done_q;
   assign o_found     = found_q;
   assign o_count     = count_q;
   assign o_xmin      = xmin_q;
   assign o_xmax      = xmax_q;
   assign o_ymin      = ymin_q;
   assign o_ymax      = ymax_q;
   assign o_frame_err = frame_err_q;

`ifdef COLOR_MASK_OUT_EN
   assign o_mask_valid = s2_v_q;
   assign o_mask       = s2_match_q;
   assign o_mask_x     = s2_x_q;
   assign o_mask_y     = s2_y_q;
`endif

endmodule

// File: tb/tb_color_bbox_detect.sv
// Directed bench for color_bbox_detect on a reduced 32x24 frame; expected results are hand-computed per scenario.
module tb_color_bbox_detect;

   localparam int H  = 32;
   localparam int V  = 24;
   localparam int XW = 10;
   localparam int YW = 9;
   localparam int CW = 19;

   logic          clk = 1'b0;
   logic          i_rst, i_sof, o_obuf_rd, i_obuf_empty;
   logic [15:0]   i_obuf_data;
   logic [4:0]    i_r_min, i_r_max, i_b_min, i_b_max;
   logic [5:0]    i_g_min, i_g_max;
   logic          o_done, o_found, o_frame_err;
   logic [CW-1:0] o_count;
   logic [XW-1:0] o_xmin, o_xmax;
   logic [YW-1:0] o_ymin, o_ymax;
`ifdef COLOR_MASK_OUT_EN
   logic          o_mask_valid, o_mask;
   logic [XW-1:0] o_mask_x;
   logic [YW-1:0] o_mask_y;
`endif

   int total = 0;
   int bad   = 0;
   int n_done, lat;

   always #5 clk = ~clk;

   color_bbox_detect #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .CW(CW)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_sof(i_sof),
      .o_obuf_rd(o_obuf_rd), .i_obuf_data(i_obuf_data), .i_obuf_empty(i_obuf_empty),
      .i_r_min(i_r_min), .i_r_max(i_r_max), .i_g_min(i_g_min), .i_g_max(i_g_max),
      .i_b_min(i_b_min), .i_b_max(i_b_max),
      .o_done(o_done), .o_found(o_found), .o_count(o_count),
      .o_xmin(o_xmin), .o_xmax(o_xmax), .o_ymin(o_ymin), .o_ymax(o_ymax),
      .o_frame_err(o_frame_err)
`ifdef COLOR_MASK_OUT_EN
      ,
      .o_mask_valid(o_mask_valid), .o_mask(o_mask), .o_mask_x(o_mask_x), .o_mask_y(o_mask_y)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Frame content per scenario: 0 all black, 1 red dot (10,5), 2 red 10x10 square, 3 all red, 4 red dot (5,0).
   function automatic logic [15:0] pix(input int mode, input int k);
      int x = k % H;
      int y = k / H;
      case (mode)
         1:       return (x == 10 && y == 5) ? 16'hF800 : 16'h0000;
         2:       return (x >= 20 && x <= 29 && y >= 10 && y <= 19) ? 16'hF800 : 16'h0000;
         3:       return 16'hF800;
         4:       return (x == 5 && y == 0) ? 16'hF800 : 16'h0000;
         default: return 16'h0000;
      endcase
   endfunction

   task automatic pulse_sof();
      @(posedge clk); #1;
      i_obuf_empty = 1'b1;
      i_sof        = 1'b1;
      @(posedge clk); #1;
      i_sof = 1'b0;
   endtask

   // Plays the FIFO: data follows each sampled read by one cycle; counts o_done and its distance from the last read.
   task automatic feed(input int mode, input int npix, input bit stall, input int drain,
                       output int nd, output int latency);
      bit rd_prev   = 1'b0;
      int rd_cnt    = 0;
      int last_rd   = -1;
      int done_cyc  = -1;
      int cyc       = 0;
`ifdef COLOR_MASK_OUT_EN
      int mask_cyc  = -1;
`endif
      nd = 0;
      while (1) begin
         @(posedge clk); #1;
         if (rd_prev) i_obuf_data = pix(mode, rd_cnt - 1);
         if (o_done) begin
            nd++;
            done_cyc = cyc;
         end
`ifdef COLOR_MASK_OUT_EN
         if (cyc == mask_cyc) begin
            check("mask_valid", 32'(o_mask_valid), 32'd1);
            check("mask_bit",   32'(o_mask),       32'd1);
            check("mask_x",     32'(o_mask_x),     32'd5);
            check("mask_y",     32'(o_mask_y),     32'd0);
         end
`endif
         i_obuf_empty = (rd_cnt >= npix) || (stall && (cyc % 3 == 2));
         #1;
         rd_prev = o_obuf_rd;
         if (rd_prev) begin
`ifdef COLOR_MASK_OUT_EN
            if (mode == 4 && rd_cnt == 5) mask_cyc = cyc + 2;
`endif
            last_rd = cyc;
            rd_cnt++;
         end
         if (rd_cnt >= npix && cyc >= last_rd + drain) break;
         if (cyc > 4000) begin
            check("feed_timeout_reads", 32'(rd_cnt), 32'(npix));
            break;
         end
         cyc++;
      end
      latency = (done_cyc >= 0) ? done_cyc - last_rd : -1;
   endtask

   task automatic check_result(input string tag, input int cnt, input int x0, input int x1,
                               input int y0, input int y1);
      check({tag, "_found"}, 32'(o_found), (cnt != 0) ? 32'd1 : 32'd0);
      check({tag, "_count"}, 32'(o_count), 32'(cnt));
      check({tag, "_xmin"},  32'(o_xmin),  32'(x0));
      check({tag, "_xmax"},  32'(o_xmax),  32'(x1));
      check({tag, "_ymin"},  32'(o_ymin),  32'(y0));
      check({tag, "_ymax"},  32'(o_ymax),  32'(y1));
   endtask

   initial begin
      i_rst = 1'b1;  i_sof = 1'b0;  i_obuf_empty = 1'b1;  i_obuf_data = 16'h0000;
      i_r_min = 5'd20; i_r_max = 5'd31;
      i_g_min = 6'd0;  i_g_max = 6'd63;
      i_b_min = 5'd0;  i_b_max = 5'd31;

      repeat (2) @(posedge clk);
      #1 i_obuf_empty = 1'b0;
      #1;
      check("rst_rd",   32'(o_obuf_rd),   32'd0);
      check("rst_done", 32'(o_done),      32'd0);
      check("rst_err",  32'(o_frame_err), 32'd0);
      check_result("rst", 0, 0, 0, 0, 0);
      @(posedge clk); #1 i_rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #2;
         check("idle_no_rd", 32'(o_obuf_rd), 32'd0);
      end

      // All-black frame: no match, bbox forced to zero despite accumulator init values.
      pulse_sof();
      feed(0, H*V, 1'b0, 8, n_done, lat);
      check("black_ndone", 32'(n_done), 32'd1);
      check_result("black", 0, 0, 0, 0, 0);

      // Single red pixel; o_done four cycles after the last read.
      pulse_sof();
      feed(1, H*V, 1'b0, 8, n_done, lat);
      check("dot_ndone",   32'(n_done), 32'd1);
      check("dot_latency", 32'(lat),    32'd4);
      check_result("dot", 1, 10, 10, 5, 5);

      // 10x10 square with the FIFO running empty every third cycle.
      pulse_sof();
      feed(2, H*V, 1'b1, 8, n_done, lat);
      check("sq_ndone", 32'(n_done), 32'd1);
      check_result("sq", 100, 20, 29, 10, 19);

`ifdef COLOR_MASK_OUT_EN
      pulse_sof();
      feed(4, H*V, 1'b0, 8, n_done, lat);
      check_result("mdot", 1, 5, 5, 0, 0);
`endif

      // Start-of-frame mid-frame: error flag, aborted frame never publishes, next frame is clean.
      pulse_sof();
      feed(3, 100, 1'b0, 2, n_done, lat);
      check("abort_ndone", 32'(n_done), 32'd0);
      pulse_sof();
      check("abort_err", 32'(o_frame_err), 32'd1);
      feed(3, H*V, 1'b0, 8, n_done, lat);
      check("full_ndone", 32'(n_done), 32'd1);
      check_result("full", H*V, 0, H-1, 0, V-1);
      check("full_err_sticky", 32'(o_frame_err), 32'd1);

      // Reset mid-frame: everything back to zero and no reads until the next start-of-frame.
      pulse_sof();
      feed(3, 50, 1'b0, 1, n_done, lat);
      @(posedge clk); #1;
      i_rst = 1'b1;
      i_obuf_empty = 1'b0;
      @(posedge clk); #1;
      check("mrst_rd",   32'(o_obuf_rd),   32'd0);
      check("mrst_done", 32'(o_done),      32'd0);
      check("mrst_err",  32'(o_frame_err), 32'd0);
      check_result("mrst", 0, 0, 0, 0, 0);
      i_rst = 1'b0;
      repeat (4) begin
         @(posedge clk); #2;
         check("mrst_no_rd", 32'(o_obuf_rd), 32'd0);
      end
      pulse_sof();
      feed(1, H*V, 1'b0, 8, n_done, lat);
      check("recover_ndone", 32'(n_done), 32'd1);
      check_result("recover", 1, 10, 10, 5, 5);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
